// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
// Slot layout plus the instruction-bus idle value and the reset level.
package if_prefetch_pkg;

    localparam int          INST_ADDR_W  = 32;
    localparam int          INST_W       = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        RST_ENABLE_N = 1'b0;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
        logic                   filled;
    } slot_t;

endpackage

// File: rtl/if_slot_queue.sv
// Ring of fetch slots: reserve at tail on grant, fill oldest unfilled on response,
// pop head once filled. Pointers carry one extra wrap bit to tell full from empty.
module if_slot_queue
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   reserve,
    input  logic [INST_ADDR_W-1:0] reserve_pc,
    input  logic                   fill,
    input  logic [INST_W-1:0]      fill_inst,
    input  logic                   pop,
    output logic [INST_ADDR_W-1:0] head_pc,
    output logic [INST_W-1:0]      head_inst,
    output logic                   head_filled,
    output logic                   full,
    output logic                   empty
);

    localparam int IDX_W = $clog2(DEPTH);

    slot_t            slots [DEPTH];
    logic [IDX_W:0]   head_ptr;
    logic [IDX_W:0]   tail_ptr;
    logic [IDX_W:0]   fill_ptr;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] fill_idx;

    assign head_idx = head_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];
    assign fill_idx = fill_ptr[IDX_W-1:0];

    assign empty = (head_ptr == tail_ptr);
    assign full  = (head_ptr[IDX_W] != tail_ptr[IDX_W]) && (head_idx == tail_idx);

    assign head_pc     = slots[head_idx].pc;
    assign head_inst   = slots[head_idx].inst;
    assign head_filled = slots[head_idx].filled;

    // Reserve, fill and pop always touch distinct slots: the parent never
    // reserves when full, only fills a reserved slot, and only pops a filled one.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (reserve) begin
                slots[tail_idx] <= '{pc: reserve_pc, inst: ZERO_WORD, filled: 1'b0};
                tail_ptr        <= tail_ptr + 1'b1;
            end
            if (fill) begin
                slots[fill_idx].inst   <= fill_inst;
                slots[fill_idx].filled <= 1'b1;
                fill_ptr               <= fill_ptr + 1'b1;
            end
            if (pop) begin
                slots[head_idx].filled <= 1'b0;
                head_ptr               <= head_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch unit: owns the fetch PC, issues in-order ROM requests,
// buffers tagged responses and presents one {pc, inst} per cycle to ID.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_req_o,
    output logic [INST_ADDR_W-1:0] rom_addr_o,
    input  logic                   rom_gnt_i,
    input  logic                   rom_rvalid_i,
    input  logic [INST_W-1:0]      rom_data_i,
    input  logic                   flush_i,
    input  logic [INST_ADDR_W-1:0] flush_pc_i,
    input  logic                   stall_i,
    output logic                   id_valid_o,
    output logic [INST_ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0]      id_inst_o
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [INST_ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]       outstanding;
    logic [CNT_W-1:0]       discard;

    logic                   issue;
    logic                   rsp_live;
    logic                   fill_ok;
    logic                   drop;
    logic                   pop;
    logic                   q_full;
    logic                   q_empty;
    logic                   head_filled;
    logic [INST_ADDR_W-1:0] head_pc;
    logic [INST_W-1:0]      head_inst;

    assign rom_req_o  = (rst != RST_ENABLE_N) && !q_full && (discard < DEPTH_C) && !flush_i;
    assign rom_addr_o = fetch_pc;
    assign issue      = rom_req_o && rom_gnt_i;

    // A stray response with nothing in flight must not underflow the counters.
    assign rsp_live = rom_rvalid_i && ((outstanding != '0) || (discard != '0));
    assign fill_ok  = rsp_live && (discard == '0) && !flush_i;
    assign drop     = rsp_live && (discard != '0);

    assign id_valid_o = head_filled && !q_empty && !flush_i;
    assign id_pc_o    = id_valid_o ? head_pc : ZERO_WORD;
    assign id_inst_o  = id_valid_o ? head_inst : ZERO_WORD;
    assign pop        = id_valid_o && !stall_i;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (flush_i) begin
            // Everything still in flight, minus a response landing right now, gets thrown away.
            fetch_pc    <= flush_pc_i;
            outstanding <= '0;
            discard     <= discard + outstanding - CNT_W'(rsp_live);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(fill_ok);
            discard     <= discard - CNT_W'(drop);
        end
    end

    if_slot_queue #(
        .DEPTH (DEPTH)
    ) u_slot_queue (
        .clk         (clk),
        .rst         (rst),
        .clear       (flush_i),
        .reserve     (issue),
        .reserve_pc  (fetch_pc),
        .fill        (fill_ok),
        .fill_inst   (rom_data_i),
        .pop         (pop),
        .head_pc     (head_pc),
        .head_inst   (head_inst),
        .head_filled (head_filled),
        .full        (q_full),
        .empty       (q_empty)
    );

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: in-order ROM model with one-cycle responses,
// expected PCs/instructions worked out by hand per step.
module tb_if_prefetch;

    logic        clk;
    logic        rst;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_data_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        stall_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    logic        rsp_en;
    logic        poison;
    logic [31:0] rom_q [$];
    logic [31:0] rom_a;
    int          vecs;
    int          errs;
    int          grants;

    if_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_data_i   (rom_data_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .stall_i      (stall_i),
        .id_valid_o   (id_valid_o),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // ROM: accepts on req&&gnt, answers one cycle later in issue order when rsp_en.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_q.delete();
            rom_rvalid_i <= 1'b0;
            rom_data_i   <= 32'h0;
        end else begin
            if (rom_req_o && rom_gnt_i) rom_q.push_back(rom_addr_o);
            if (rsp_en && rom_q.size() > 0) begin
                rom_a = rom_q.pop_front();
                rom_rvalid_i <= 1'b1;
                rom_data_i   <= (poison && rom_a < 32'h100) ? 32'hDEAD_BEEF : inst_of(rom_a);
            end else begin
                rom_rvalid_i <= 1'b0;
                rom_data_i   <= 32'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        rom_gnt_i  = 1'b0;
        rsp_en     = 1'b0;
        poison     = 1'b0;
        flush_i    = 1'b0;
        flush_pc_i = 32'h0;
        stall_i    = 1'b0;
        repeat (2) cyc();
    endtask

    initial begin
        vecs = 0;
        errs = 0;

        // 1: reset state, first ID in cycle 2, one per cycle after
        do_reset();
        rom_gnt_i = 1'b1;
        rsp_en    = 1'b1;
        #1;
        chk("rst_req", {31'h0, rom_req_o}, 32'h0);
        chk("rst_valid", {31'h0, id_valid_o}, 32'h0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0);
        rst = 1'b1;
        #1;
        chk("t1_c0_req", {31'h0, rom_req_o}, 32'h1);
        chk("t1_c0_addr", rom_addr_o, 32'h0);
        cyc();
        chk("t1_c1_valid", {31'h0, id_valid_o}, 32'h0);
        cyc();
        chk("t1_c2_addr", rom_addr_o, 32'h8);
        for (int k = 0; k < 6; k++) begin
            if (k != 0) cyc();
            chk("t1_valid", {31'h0, id_valid_o}, 32'h1);
            chk("t1_pc", id_pc_o, 32'(4 * k));
            chk("t1_inst", id_inst_o, inst_of(32'(4 * k)));
        end

        // 2: stall fills the ring, then drains back-to-back
        do_reset();
        rom_gnt_i = 1'b1;
        rsp_en    = 1'b1;
        stall_i   = 1'b1;
        rst       = 1'b1;
        #1;
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) cyc();
            if (rom_req_o && rom_gnt_i) grants++;
        end
        chk("t2_grants", 32'(grants), 32'd4);
        chk("t2_req_full", {31'h0, rom_req_o}, 32'h0);
        chk("t2_head_pc", id_pc_o, 32'h0);
        chk("t2_head_valid", {31'h0, id_valid_o}, 32'h1);
        stall_i = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) cyc();
            chk("t2_drain_valid", {31'h0, id_valid_o}, 32'h1);
            chk("t2_drain_pc", id_pc_o, 32'(4 * k));
        end

        // 3: request held without grant keeps address stable
        do_reset();
        rsp_en = 1'b1;
        rst    = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) cyc();
            chk("t3_hold_req", {31'h0, rom_req_o}, 32'h1);
            chk("t3_hold_addr", rom_addr_o, 32'h0);
        end
        cyc();
        rom_gnt_i = 1'b1;
        #1;
        cyc();
        rom_gnt_i = 1'b0;
        #1;
        chk("t3_addr_after_gnt", rom_addr_o, 32'h4);
        cyc();
        chk("t3_addr_stable", rom_addr_o, 32'h4);
        chk("t3_valid", {31'h0, id_valid_o}, 32'h1);
        chk("t3_pc", id_pc_o, 32'h0);

        // 4: flush with 2 outstanding, stale responses poisoned
        do_reset();
        rom_gnt_i = 1'b1;
        rst       = 1'b1;
        #1;
        cyc();
        cyc();
        rom_gnt_i  = 1'b0;
        flush_i    = 1'b1;
        flush_pc_i = 32'h100;
        poison     = 1'b1;
        #1;
        chk("t4_flush_req", {31'h0, rom_req_o}, 32'h0);
        chk("t4_flush_valid", {31'h0, id_valid_o}, 32'h0);
        cyc();
        flush_i   = 1'b0;
        rom_gnt_i = 1'b1;
        rsp_en    = 1'b1;
        #1;
        chk("t4_refetch_addr", rom_addr_o, 32'h100);
        for (int c = 3; c < 7; c++) begin
            if (c != 3) cyc();
            chk("t4_dropped_valid", {31'h0, id_valid_o}, 32'h0);
        end
        cyc();
        chk("t4_valid", {31'h0, id_valid_o}, 32'h1);
        chk("t4_pc", id_pc_o, 32'h100);
        chk("t4_inst", id_inst_o, inst_of(32'h100));
        cyc();
        chk("t4_pc_next", id_pc_o, 32'h104);

        // 5a: flush coinciding with a response, 3 outstanding -> two more dropped
        do_reset();
        rom_gnt_i = 1'b1;
        rst       = 1'b1;
        #1;
        cyc();
        cyc();
        rsp_en = 1'b1;
        #1;
        cyc();
        flush_i    = 1'b1;
        flush_pc_i = 32'h200;
        poison     = 1'b1;
        #1;
        chk("t5a_rvalid_in_flush", {31'h0, rom_rvalid_i}, 32'h1);
        chk("t5a_flush_valid", {31'h0, id_valid_o}, 32'h0);
        cyc();
        flush_i = 1'b0;
        #1;
        chk("t5a_refetch_addr", rom_addr_o, 32'h200);
        for (int c = 4; c < 7; c++) begin
            if (c != 4) cyc();
            chk("t5a_dropped_valid", {31'h0, id_valid_o}, 32'h0);
        end
        cyc();
        chk("t5a_valid", {31'h0, id_valid_o}, 32'h1);
        chk("t5a_pc", id_pc_o, 32'h200);
        cyc();
        chk("t5a_pc_next", id_pc_o, 32'h204);

        // 5b: flush while stalled with a full ring
        do_reset();
        rom_gnt_i = 1'b1;
        rsp_en    = 1'b1;
        stall_i   = 1'b1;
        rst       = 1'b1;
        #1;
        repeat (8) cyc();
        chk("t5b_full_req", {31'h0, rom_req_o}, 32'h0);
        flush_i    = 1'b1;
        flush_pc_i = 32'h300;
        #1;
        chk("t5b_flush_valid", {31'h0, id_valid_o}, 32'h0);
        chk("t5b_flush_req", {31'h0, rom_req_o}, 32'h0);
        cyc();
        flush_i = 1'b0;
        stall_i = 1'b0;
        #1;
        chk("t5b_empty_valid", {31'h0, id_valid_o}, 32'h0);
        chk("t5b_refetch_req", {31'h0, rom_req_o}, 32'h1);
        chk("t5b_refetch_addr", rom_addr_o, 32'h300);
        cyc();
        cyc();
        chk("t5b_valid", {31'h0, id_valid_o}, 32'h1);
        chk("t5b_pc", id_pc_o, 32'h300);

        // 6: async reset with 3 filled slots
        do_reset();
        rom_gnt_i = 1'b1;
        rsp_en    = 1'b1;
        stall_i   = 1'b1;
        rst       = 1'b1;
        #1;
        cyc();
        cyc();
        cyc();
        rom_gnt_i = 1'b0;
        #1;
        cyc();
        chk("t6_pre_valid", {31'h0, id_valid_o}, 32'h1);
        chk("t6_pre_pc", id_pc_o, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_async_req", {31'h0, rom_req_o}, 32'h0);
        chk("t6_async_valid", {31'h0, id_valid_o}, 32'h0);
        chk("t6_async_pc", id_pc_o, 32'h0);
        chk("t6_async_inst", id_inst_o, 32'h0);
        cyc();
        stall_i   = 1'b0;
        rom_gnt_i = 1'b1;
        rst       = 1'b1;
        #1;
        chk("t6_restart_addr", rom_addr_o, 32'h0);
        cyc();
        cyc();
        chk("t6_restart_pc0", id_pc_o, 32'h0);
        cyc();
        chk("t6_restart_pc1", id_pc_o, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
